// File: rtl/alu_ops_pkg.sv
// Operation codes shared by ALU control, the ALU and the multiply/divide unit.
// Helpers classify the MDU codes so the decode lives in one place.
package alu_ops_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MTHI  = 4'b1100,
        OP_MTLO  = 4'b1101
    } alu_op_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the issue stage and the multiply/divide unit.
// Requests are only honoured while busy is low; there is no other backpressure.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [3:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, operation, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, operation, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negate: takes magnitudes in PREP, restores signs in FIX.
// Purely combinational, zero latency.
module mdu_sign_fix #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit with HI/LO registers.
// Start to Done is WIDTH+2 edges; starts arriving while busy are dropped.
module mult_div_unit
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

    state_e           state;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, opnd, acc_hi, acc_lo;
    logic [CW-1:0]    cnt;
    logic             neg_lo, neg_hi;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r, dz_r;

    logic             a_neg, b_neg, div_op;
    logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;

    assign div_op = is_div_op(op_r);
    assign a_neg  = is_signed_op(op_r) && a_r[WIDTH-1];
    assign b_neg  = is_signed_op(op_r) && b_r[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.val(a_r), .neg(a_neg), .res(a_mag));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.val(b_r), .neg(b_neg), .res(b_mag));
    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.val({acc_hi, acc_lo}), .neg(neg_lo), .res(prod_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.val(acc_lo), .neg(neg_lo), .res(quo_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.val(acc_hi), .neg(neg_hi), .res(rem_fix));

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide keeps the dividend in acc_lo and shifts quotient bits in from the bottom.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (is_iter_op(bus.operation)) begin
                            op_r  <= bus.operation;
                            a_r   <= bus.a;
                            b_r   <= bus.b;
                            state <= S_PREP;
                        end else if (bus.operation == OP_MTHI) begin
                            hi_r <= bus.a;
                        end else if (bus.operation == OP_MTLO) begin
                            lo_r <= bus.a;
                        end
                    end
                end
                S_PREP: begin
                    acc_hi <= '0;
                    cnt    <= '0;
                    neg_lo <= a_neg ^ b_neg;
                    neg_hi <= a_neg;
                    if (div_op) begin
                        acc_lo <= a_mag;
                        opnd   <= b_mag;
                    end else begin
                        acc_lo <= b_mag;
                        opnd   <= a_mag;
                    end
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (div_op) begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (div_op) begin
                        // Divide by zero reports the untouched dividend, not the iterated remainder.
                        if (b_r == '0) begin
                            hi_r <= a_r;
                            lo_r <= '1;
                            dz_r <= 1'b1;
                        end else begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: directed cases plus randomized ops against a plain-arithmetic model.
module tb_mult_div_unit;
    import alu_ops_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] hi_m, lo_m;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) mdu ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mdu)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference results from ordinary 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        h  = '0;
        l  = '0;
        if (op == OP_MULT) begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
        end else if (op == OP_MULTU) begin
            p = ua * ub;
            h = p[63:32];
            l = p[31:0];
        end else if (b == '0) begin
            h  = a;
            l  = '1;
            dz = 1'b1;
        end else if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            p = 64'(q);
            l = p[31:0];
            p = 64'(r);
            h = p[31:0];
        end else begin
            p = ua / ub;
            l = p[31:0];
            p = ua % ub;
            h = p[31:0];
        end
    endtask

    // Called just after a negedge; returns at the negedge following the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        mdu.start     = 1'b1;
        mdu.operation = op;
        mdu.a         = a;
        mdu.b         = b;
        @(negedge clk);
        mdu.start = 1'b0;
    endtask

    task automatic wait_done(input int base, output int lat);
        lat = 0;
        for (int k = base + 1; k <= base + 60; k++) begin
            @(negedge clk);
            if (mdu.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        logic edz;
        int lat;
        model(op, a, b, eh, el, edz);
        issue(op, a, b);
        chk({tag, " busy"}, 64'(mdu.busy), 64'd1);
        wait_done(0, lat);
        chk({tag, " latency"}, 64'(lat), 64'(W + 2));
        chk({tag, " hi"}, 64'(mdu.hi), 64'(eh));
        chk({tag, " lo"}, 64'(mdu.lo), 64'(el));
        chk({tag, " divzero"}, 64'(mdu.div_zero), 64'(edz));
        chk({tag, " idle"}, 64'(mdu.busy), 64'd0);
        hi_m = eh;
        lo_m = el;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};
        if ($urandom_range(2) == 0)
            return corners[$urandom_range(5)];
        return W'($urandom());
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] optab [8];
        logic [3:0] op;
        logic [W-1:0] ra, rb;
        int lat, seen;
        optab = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, 4'b0010, 4'b1111};

        reset = 1'b1;
        mdu.start = 1'b0;
        mdu.operation = '0;
        mdu.a = '0;
        mdu.b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", 64'(mdu.busy), 64'd0);
        chk("reset done", 64'(mdu.done), 64'd0);
        chk("reset divzero", 64'(mdu.div_zero), 64'd0);
        chk("reset hi", 64'(mdu.hi), 64'd0);
        chk("reset lo", 64'(mdu.lo), 64'd0);

        run_op("t1 mult", OP_MULT, 32'hFFFF_FFFD, 32'd5);
        chk("t1 hi const", 64'(mdu.hi), 64'hFFFF_FFFF);
        chk("t1 lo const", 64'(mdu.lo), 64'hFFFF_FFF1);
        run_op("t2 multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t2 hi const", 64'(mdu.hi), 64'hFFFF_FFFE);
        chk("t2 lo const", 64'(mdu.lo), 64'h1);
        run_op("t3 div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("t3 lo const", 64'(mdu.lo), 64'hFFFF_FFFD);
        chk("t3 hi const", 64'(mdu.hi), 64'hFFFF_FFFF);
        run_op("t3 divu", OP_DIVU, 32'd100, 32'd7);
        chk("t3 divu lo const", 64'(mdu.lo), 64'd14);
        chk("t3 divu hi const", 64'(mdu.hi), 64'd2);
        run_op("t4 divu0", OP_DIVU, 32'h1234, 32'h0);
        chk("t4 divzero const", 64'(mdu.div_zero), 64'd1);
        chk("t4 lo const", 64'(mdu.lo), 64'hFFFF_FFFF);
        chk("t4 hi const", 64'(mdu.hi), 64'h1234);
        run_op("overflow div", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("overflow lo const", 64'(mdu.lo), 64'h8000_0000);

        // MTHI while busy must be dropped; MTLO in the Done cycle must be taken.
        issue(OP_MULT, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        issue(OP_MTHI, 32'hDEAD, 32'd0);
        wait_done(10, lat);
        chk("t5 latency", 64'(lat), 64'(W + 2));
        chk("t5 hi", 64'(mdu.hi), 64'd0);
        chk("t5 lo", 64'(mdu.lo), 64'd42);
        issue(OP_MTLO, 32'hBEEF, 32'd0);
        chk("t5 mtlo lo", 64'(mdu.lo), 64'hBEEF);
        chk("t5 mtlo hi", 64'(mdu.hi), 64'd0);
        chk("t5 mtlo busy", 64'(mdu.busy), 64'd0);
        hi_m = '0;
        lo_m = 32'hBEEF;

        // Reset in the middle of a divide aborts it without a Done pulse.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6 busy", 64'(mdu.busy), 64'd0);
        chk("t6 hi", 64'(mdu.hi), 64'd0);
        chk("t6 lo", 64'(mdu.lo), 64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (mdu.done) seen++;
            @(negedge clk);
        end
        chk("t6 no done", 64'(seen), 64'd0);
        run_op("t6 mult", OP_MULT, 32'd2, 32'd3);
        chk("t6 lo const", 64'(mdu.lo), 64'd6);

        for (int i = 0; i < 30; i++) begin
            op = optab[$urandom_range(7)];
            ra = pick();
            rb = pick();
            if (is_iter_op(op)) begin
                run_op($sformatf("rand%0d op%0h", i, op), op, ra, rb);
            end else begin
                if (op == OP_MTHI) hi_m = ra;
                else if (op == OP_MTLO) lo_m = ra;
                issue(op, ra, rb);
                chk($sformatf("rand%0d op%0h busy", i, op), 64'(mdu.busy), 64'd0);
                chk($sformatf("rand%0d op%0h hi", i, op), 64'(mdu.hi), 64'(hi_m));
                chk($sformatf("rand%0d op%0h lo", i, op), 64'(mdu.lo), 64'(lo_m));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
